// File: rtl/hbm_writeback_arbiter.sv
// Per-lane write-back FIFOs, round-robin drained onto one HBM write port.
// Define HBM_WB_STATS_EN to add drop_count / grant_count statistics ports.
module hbm_writeback_arbiter #(
  parameter int EDGE_PIPELINE_NUM = 4,
  parameter int VERTEX_AWIDTH     = 16,
  parameter int VERTEX_DWIDTH     = 32,
  parameter int FIFO_DEPTH        = 8,
  parameter int FIFO_AWIDTH       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic [EDGE_PIPELINE_NUM*VERTEX_AWIDTH-1:0] lane_addr,
  input  logic [EDGE_PIPELINE_NUM*VERTEX_DWIDTH-1:0] lane_data,
  input  logic [EDGE_PIPELINE_NUM-1:0]               lane_valid,
  output logic [VERTEX_AWIDTH-1:0]                   hbm_addr,
  output logic [VERTEX_DWIDTH-1:0]                   hbm_data,
  output logic                                       hbm_valid,
  input  logic                                       hbm_ready,
  output logic [EDGE_PIPELINE_NUM-1:0]               lane_almost_full,
  output logic [EDGE_PIPELINE_NUM-1:0]               overflow,
  input  logic                                       drain,
  output logic                                       drain_done
`ifdef HBM_WB_STATS_EN
  ,
  output logic [31:0]                                drop_count,
  output logic [31:0]                                grant_count
`endif
);

  localparam int N  = EDGE_PIPELINE_NUM;
  localparam int AW = VERTEX_AWIDTH;
  localparam int DW = VERTEX_DWIDTH;
  localparam int EW = AW + DW;
  localparam int CW = FIFO_AWIDTH + 1;
  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  typedef logic [EW-1:0] ent_t;

  ent_t                   mem_q [N][FIFO_DEPTH];
  ent_t                   mem_d [N][FIFO_DEPTH];
  logic [FIFO_AWIDTH-1:0] wp_q [N], wp_d [N];
  logic [FIFO_AWIDTH-1:0] rp_q [N], rp_d [N];
  logic [CW-1:0]          cnt_q [N], cnt_d [N];

  logic [PW-1:0] rr_q, rr_d, gnt;
  logic          found, free;
  logic [N-1:0]  nonempty, pop, push, drop;
  logic [N-1:0]  af_q, af_d, ovf_q, ovf_d;
  logic          vld_q, vld_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  state_t        state_q, state_d;
  logic          done_q, done_d;

  always_comb begin
    for (int i = 0; i < N; i++) nonempty[i] = cnt_q[i] != '0;
  end

  // first non-empty lane at or after rr_q
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        gnt   = PW'(idx);
      end
    end
  end

  always_comb begin
    logic full;
    free   = !vld_q || hbm_ready;
    mem_d  = mem_q;
    full   = 1'b0;
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    rr_d   = rr_q;
    for (int i = 0; i < N; i++) begin
      full    = cnt_q[i] == CW'(FIFO_DEPTH);
      pop[i]  = free && found && (gnt == PW'(i));
      push[i] = lane_valid[i] && (!full || pop[i]);
      drop[i] = lane_valid[i] && full && !pop[i];
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      wp_d[i]  = wp_q[i] + FIFO_AWIDTH'(push[i]);
      rp_d[i]  = rp_q[i] + FIFO_AWIDTH'(pop[i]);
      if (push[i])
        mem_d[i][wp_q[i]] = {lane_addr[i*AW +: AW],
                             lane_data[i*DW +: DW]};
      af_d[i] = cnt_d[i] >= CW'(FIFO_DEPTH - 2);
    end
    ovf_d = ovf_q | drop;
    if (free) begin
      vld_d = found;
      if (found) begin
        {addr_d, data_d} = mem_q[gnt][rp_q[gnt]];
        rr_d = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (drain) state_d = DRAIN;
      DRAIN: if (!(|nonempty) && !vld_q && !(|push))
               state_d = DONE;
      DONE:  state_d = RUN;
      default: state_d = RUN;
    endcase
    done_d = state_d == DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
        for (int j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= '0;
      end
      rr_q    <= '0;
      af_q    <= '0;
      ovf_q   <= '0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      state_q <= RUN;
      done_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign hbm_addr         = addr_q;
  assign hbm_data         = data_q;
  assign hbm_valid        = vld_q;
  assign lane_almost_full = af_q;
  assign overflow         = ovf_q;
  assign drain_done       = done_q;

`ifdef HBM_WB_STATS_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] grant_cnt_q, grant_cnt_d;
  logic [32:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < N; i++) drop_sum = drop_sum + 33'(drop[i]);
    drop_cnt_d  = drop_sum[32] ? '1 : drop_sum[31:0];
    grant_cnt_d = grant_cnt_q + 32'(vld_q && hbm_ready);
    if (state_q == DONE) begin
      drop_cnt_d  = '0;
      grant_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q  <= '0;
      grant_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign drop_count  = drop_cnt_q;
  assign grant_count = grant_cnt_q;
`endif

endmodule
